// File: rtl/pf_osc_tick_gen.sv
// Microsecond / millisecond tick generator running from an RC oscillator clock.
// Waits for the oscillator to settle, then divides CLK into TICK_US and TICK_MS strobes.
module pf_osc_tick_gen #(
  parameter int unsigned CLK_FREQ_MHZ   = 160,
  parameter int unsigned TICK_MS_DIV    = 1000,
  parameter int unsigned STARTUP_CYCLES = 1024
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic        CLEAR,
  output logic        OSC_READY,
  output logic        TICK_US,
  output logic        TICK_MS,
  output logic [31:0] MS_COUNT
);

  localparam logic [9:0]  PRESC_LAST   = 10'(CLK_FREQ_MHZ - 1);
  localparam logic [9:0]  US_LAST      = 10'(TICK_MS_DIV - 1);
  localparam logic [15:0] STARTUP_LAST = 16'(STARTUP_CYCLES - 1);

  typedef enum logic {
    StStartup,
    StRun
  } state_e;

  state_e      r_state;
  logic [15:0] r_startup_cnt;
  logic [9:0]  r_presc;
  logic [9:0]  r_us_cnt;
  logic [31:0] r_ms_count;
  logic        r_osc_ready;
  logic        r_tick_us;
  logic        r_tick_ms;

  state_e      w_state_nxt;
  logic [15:0] w_startup_nxt;
  logic [9:0]  w_presc_nxt;
  logic [9:0]  w_us_nxt;
  logic [31:0] w_ms_nxt;
  logic        w_ready_nxt;
  logic        w_tick_us_nxt;
  logic        w_tick_ms_nxt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state       <= StStartup;
      r_startup_cnt <= '0;
      r_presc       <= '0;
      r_us_cnt      <= '0;
      r_ms_count    <= '0;
      r_osc_ready   <= 1'b0;
      r_tick_us     <= 1'b0;
      r_tick_ms     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_startup_cnt <= w_startup_nxt;
      r_presc       <= w_presc_nxt;
      r_us_cnt      <= w_us_nxt;
      r_ms_count    <= w_ms_nxt;
      r_osc_ready   <= w_ready_nxt;
      r_tick_us     <= w_tick_us_nxt;
      r_tick_ms     <= w_tick_ms_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_startup_nxt = r_startup_cnt;
    w_presc_nxt   = r_presc;
    w_us_nxt      = r_us_cnt;
    w_ms_nxt      = r_ms_count;
    w_ready_nxt   = r_osc_ready;
    w_tick_us_nxt = 1'b0;
    w_tick_ms_nxt = 1'b0;
    unique case (r_state)
      StStartup: begin
        // ENABLE and CLEAR have no effect until the oscillator has settled
        if (r_startup_cnt == STARTUP_LAST) begin
          w_state_nxt = StRun;
          w_ready_nxt = 1'b1;
        end else begin
          w_startup_nxt = r_startup_cnt + 16'd1;
        end
      end
      StRun: begin
        w_ready_nxt = 1'b1;
        if (CLEAR) begin
          w_presc_nxt = '0;
          w_us_nxt    = '0;
          w_ms_nxt    = '0;
        end else if (ENABLE) begin
          if (r_presc == PRESC_LAST) begin
            w_presc_nxt   = '0;
            w_tick_us_nxt = 1'b1;
            if (r_us_cnt == US_LAST) begin
              w_us_nxt      = '0;
              w_tick_ms_nxt = 1'b1;
              w_ms_nxt      = r_ms_count + 32'd1;
            end else begin
              w_us_nxt = r_us_cnt + 10'd1;
            end
          end else begin
            w_presc_nxt = r_presc + 10'd1;
          end
        end
      end
      default: w_state_nxt = StStartup;
    endcase
  end

  assign OSC_READY = r_osc_ready;
  assign TICK_US   = r_tick_us;
  assign TICK_MS   = r_tick_ms;
  assign MS_COUNT  = r_ms_count;

endmodule

// File: tb/tb_pf_osc_tick_gen.sv
// Self-checking bench for pf_osc_tick_gen: directed scenarios with fixed edge numbers plus
// randomized ENABLE/CLEAR/RESET traffic compared against an arithmetic reference model.
module tb_pf_osc_tick_gen;
  localparam int F = 4;
  localparam int D = 3;
  localparam int S = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, en = 1'b0, clr = 1'b0;
  logic ready, tus, tms;
  logic [31:0] msc;

  logic rst_def = 1'b1;
  logic def_ready, def_tus, def_tms;
  logic [31:0] def_msc;

  int checks = 0;
  int failures = 0;

  pf_osc_tick_gen #(.CLK_FREQ_MHZ(F), .TICK_MS_DIV(D), .STARTUP_CYCLES(S)) dut (
    .CLK(clk), .RESET(rst), .ENABLE(en), .CLEAR(clr),
    .OSC_READY(ready), .TICK_US(tus), .TICK_MS(tms), .MS_COUNT(msc)
  );

  pf_osc_tick_gen dut_def (
    .CLK(clk), .RESET(rst_def), .ENABLE(1'b1), .CLEAR(1'b0),
    .OSC_READY(def_ready), .TICK_US(def_tus), .TICK_MS(def_tms), .MS_COUNT(def_msc)
  );

  // Reference model: ticks follow from the total number of enabled RUN cycles since clear.
  int unsigned m_since;
  longint      m_en;
  logic        m_ready, m_tus, m_tms;
  logic [31:0] m_ms;
  logic        pre_req = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_since <= 0; m_en <= 0; m_ready <= 1'b0; m_tus <= 1'b0; m_tms <= 1'b0; m_ms <= '0;
    end else if (!m_ready) begin
      m_since <= m_since + 1;
      if (m_since + 1 == S) m_ready <= 1'b1;
      m_tus <= 1'b0; m_tms <= 1'b0;
    end else if (clr) begin
      m_en <= 0; m_ms <= '0; m_tus <= 1'b0; m_tms <= 1'b0;
    end else if (en) begin
      m_en  <= m_en + 1;
      m_tus <= ((m_en + 1) % F) == 0;
      m_tms <= ((m_en + 1) % (F * D)) == 0;
      if (((m_en + 1) % (F * D)) == 0) m_ms <= m_ms + 32'd1;
    end else begin
      m_tus <= 1'b0; m_tms <= 1'b0;
    end
    if (pre_req) m_ms <= 32'hFFFF_FFFF;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reset held, then released; returns with edge 0 just done (next cyc() is edge 1).
  task automatic do_reset();
    rst = 1'b1; clr = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; clr = 1'b1;
    cyc(); cyc();
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
    checks++; if (tus !== 1'b0) begin failures++; $display("FAIL reset_tick_us got=%b exp=0", tus); end
    checks++; if (tms !== 1'b0) begin failures++; $display("FAIL reset_tick_ms got=%b exp=0", tms); end
    checks++; if (msc !== 32'd0) begin failures++; $display("FAIL reset_ms_count got=%0d exp=0", msc); end
    clr = 1'b0;
  endtask

  task automatic test_startup();
    do_reset();
    en = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      clr = (e == 2 || e == 3);
      cyc();
      checks++;
      if (ready !== (e >= S)) begin
        failures++; $display("FAIL startup_ready edge=%0d got=%b exp=%b", e, ready, e >= S);
      end
      checks++;
      if (tus !== (e == 9 || e == 13 || e == 17)) begin
        failures++; $display("FAIL startup_tick_us edge=%0d got=%b", e, tus);
      end
      checks++;
      if (tms !== (e == 17)) begin
        failures++; $display("FAIL startup_tick_ms edge=%0d got=%b", e, tms);
      end
      checks++;
      if (msc !== ((e >= 17) ? 32'd1 : 32'd0)) begin
        failures++; $display("FAIL startup_ms_count edge=%0d got=%0d", e, msc);
      end
    end
    clr = 1'b0;
  endtask

  task automatic test_enable_gap();
    do_reset();
    for (int e = 1; e <= 26; e++) begin
      en = !(e >= 8 && e <= 14);
      cyc();
      checks++;
      if (tus !== (e == 16 || e == 20 || e == 24)) begin
        failures++; $display("FAIL gap_tick_us edge=%0d got=%b", e, tus);
      end
      checks++;
      if (msc !== ((e >= 24) ? 32'd1 : 32'd0) || tms !== (e == 24)) begin
        failures++; $display("FAIL gap_ms edge=%0d got tms=%b cnt=%0d", e, tms, msc);
      end
    end
  endtask

  task automatic test_clear();
    do_reset();
    en = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      clr = (e == 17);
      cyc();
      checks++;
      if (tus !== (e == 9 || e == 13 || e == 21 || e == 25 || e == 29)) begin
        failures++; $display("FAIL clear_tick_us edge=%0d got=%b", e, tus);
      end
      checks++;
      if (tms !== (e == 29) || msc !== ((e >= 29) ? 32'd1 : 32'd0)) begin
        failures++; $display("FAIL clear_ms edge=%0d got tms=%b cnt=%0d", e, tms, msc);
      end
    end
    clr = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    en = 1'b1;
    for (int e = 1; e <= 10; e++) cyc();
    rst = 1'b1;
    cyc();
    checks++;
    if ({ready, tus, tms} !== 3'b000 || msc !== 32'd0) begin
      failures++; $display("FAIL midrun_reset got ready=%b tus=%b tms=%b cnt=%0d", ready, tus,
                           tms, msc);
    end
    cyc();
    rst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      cyc();
      checks++;
      if (ready !== (e >= S)) begin
        failures++; $display("FAIL midrun_ready edge=%0d got=%b exp=%b", e, ready, e >= S);
      end
    end
  endtask

  task automatic test_ms_wrap();
    bit seen = 1'b0;
    do_reset();
    en = 1'b1;
    for (int e = 1; e <= S; e++) cyc();
    en = 1'b0;
    force dut.r_ms_count = 32'hFFFF_FFFF;
    pre_req = 1'b1;
    cyc();
    release dut.r_ms_count;
    pre_req = 1'b0;
    checks++;
    if (msc !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL wrap_preload got=%h exp=ffffffff", msc);
    end
    en = 1'b1;
    for (int e = 1; e <= 20 && !seen; e++) begin
      cyc();
      if (tms === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (msc !== 32'd0 || e != F * D) begin
          failures++; $display("FAIL wrap_ms_count got=%h at=%0d exp=0 at=%0d", msc, e, F * D);
        end
      end
    end
    if (!seen) begin
      checks++; failures++; $display("FAIL wrap_timeout got=no_tick_ms exp=tick_ms");
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      en  = ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 199) == 0);
      cyc();
      checks++;
      if (ready !== m_ready || tus !== m_tus || tms !== m_tms || msc !== m_ms) begin
        failures++;
        $display("FAIL random_cycle=%0d got r=%b us=%b ms=%b cnt=%0d exp r=%b us=%b ms=%b cnt=%0d",
                 i, ready, tus, tms, msc, m_ready, m_tus, m_tms, m_ms);
      end
    end
    rst = 1'b0; clr = 1'b0;
  endtask

  task automatic test_defaults();
    int rdy_at = -1, t1 = -1, t2 = -1;
    rst_def = 1'b1;
    cyc(); cyc();
    rst_def = 1'b0;
    for (int e = 1; e <= 1500 && t2 < 0; e++) begin
      cyc();
      if (def_ready === 1'b1 && rdy_at < 0) rdy_at = e;
      if (def_tus === 1'b1) begin
        if (t1 < 0) t1 = e;
        else t2 = e;
      end
      if (def_tms !== 1'b0 || def_msc !== 32'd0) begin
        checks++; failures++;
        $display("FAIL def_ms edge=%0d got tms=%b cnt=%0d exp 0", e, def_tms, def_msc);
      end
    end
    checks++;
    if (rdy_at != 1024) begin failures++; $display("FAIL def_ready got=%0d exp=1024", rdy_at); end
    checks++;
    if (t1 != 1024 + 160) begin failures++; $display("FAIL def_first_us got=%0d exp=1184", t1); end
    checks++;
    if (t2 - t1 != 160) begin failures++; $display("FAIL def_us_period got=%0d exp=160", t2 - t1); end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_enable_gap();
    test_clear();
    test_reset_mid_run();
    test_ms_wrap();
    test_random();
    test_defaults();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pf_osc_tick_gen.md
PF_OSC_TICK_GEN -- requirements
Module: pf_osc_tick_gen

Interface
REQ-001 SHALL have parameter CLK_FREQ_MHZ, default 160, CLK cycles per microsecond; legal range 2..1023.
REQ-002 SHALL have parameter TICK_MS_DIV, default 1000, microsecond ticks per millisecond tick; legal range 2..1023.
REQ-003 SHALL have parameter STARTUP_CYCLES, default 1024, CLK cycles of oscillator settling before ticks start; legal range 1..65535.
REQ-004 SHALL have port CLK  input  1  on-chip RC oscillator global clock (160 MHz); sole clock, all logic on rising edge.
REQ-005 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-006 SHALL have port ENABLE  input  1  level; high lets the tick counters advance.
REQ-007 SHALL have port CLEAR  input  1  synchronous clear of the tick counters and MS_COUNT.
REQ-008 SHALL have port OSC_READY  output  1  high once the settling period is complete.
REQ-009 SHALL have port TICK_US  output  1  one-cycle strobe per microsecond.
REQ-010 SHALL have port TICK_MS  output  1  one-cycle strobe per millisecond.
REQ-011 SHALL have port MS_COUNT  output  32  free-running millisecond count.

Function
REQ-012 SHALL implement a two-state machine, STARTUP and RUN, with every output registered.
REQ-013 STARTUP SHALL count CLK cycles; ENABLE and CLEAR are ignored; TICK_US/TICK_MS held 0.
REQ-014 STARTUP SHALL move to RUN on the edge completing cycle STARTUP_CYCLES after RESET deassertion; OSC_READY goes high on that same edge.
REQ-015 RUN SHALL be left only by RESET; OSC_READY stays high in RUN.
REQ-016 In RUN, a prescaler SHALL count 0..CLK_FREQ_MHZ-1, advancing only in cycles with ENABLE=1, and wrap to 0.
REQ-017 TICK_US SHALL be high for exactly the one cycle after the prescaler wraps, giving one strobe per CLK_FREQ_MHZ enabled cycles; first strobe follows exactly CLK_FREQ_MHZ enabled RUN cycles.
REQ-018 A microsecond counter SHALL count 0..TICK_MS_DIV-1, advancing once per prescaler wrap, and wrap to 0.
REQ-019 TICK_MS SHALL be high in the same cycle as the TICK_US caused by the microsecond counter wrapping; never otherwise.
REQ-020 MS_COUNT SHALL increment by 1 in the cycle TICK_MS is high; it wraps from 0xFFFFFFFF to 0.
REQ-021 ENABLE=0 in RUN SHALL freeze prescaler, microsecond counter and MS_COUNT; TICK_US/TICK_MS are 0 the following cycle; counting resumes from the frozen value.
REQ-022 CLEAR=1 in RUN SHALL zero prescaler, microsecond counter and MS_COUNT, and force TICK_US/TICK_MS to 0 on the next edge; CLEAR has priority over ENABLE and over a coincident wrap.
REQ-023 Counter widths SHALL be clog2 of the parameter range (10 bits prescaler/µs, 16 bits startup); no arithmetic overflow within legal parameters.

Reset
REQ-024 RESET=1 sampled on any edge SHALL force STARTUP, zero all counters, OSC_READY=0, TICK_US=0, TICK_MS=0, MS_COUNT=0 on that edge, regardless of state, ENABLE or CLEAR.
REQ-025 RESET asserted mid-RUN SHALL restart the full STARTUP_CYCLES settling period after deassertion.
REQ-026 RESET SHALL have priority over every other input.

Verification (bench parameters CLK_FREQ_MHZ=4, TICK_MS_DIV=3, STARTUP_CYCLES=5 unless stated)
REQ-027 Release RESET, ENABLE=1 -> OSC_READY rises on edge 5, first TICK_US on edge 9, then every 4 cycles; TICK_MS with 3rd TICK_US (edge 17); MS_COUNT=1 after edge 17.
REQ-028 ENABLE toggled low for 7 cycles mid-prescale -> no strobes during gap; next TICK_US exactly 7 cycles later than nominal; MS_COUNT unchanged.
REQ-029 CLEAR pulsed in the cycle a TICK_MS would occur, ENABLE=1 -> no TICK_MS, MS_COUNT=0, next TICK_US 4 enabled cycles after CLEAR; CLEAR during STARTUP has no effect.
REQ-030 Force MS_COUNT to 0xFFFFFFFF via long run (or defaults with preloaded state) -> next TICK_MS yields MS_COUNT=0x00000000.
REQ-031 RESET asserted 2 cycles after a TICK_US in RUN -> all outputs 0 next edge; OSC_READY re-rises 5 cycles after RESET release.
REQ-032 Defaults (160/1000/1024) -> TICK_US period 160 cycles, TICK_MS period 160000 cycles, OSC_READY at cycle 1024.
